i2s_tx_fifo: RTL

Parametrised I2S transmit engine for the codec link. It runs entirely in the Clk domain, synchronises the codec-mastered SCLK/LRCLK pins, and shifts stereo samples out MSB-first with the standard one-bit I2S delay. Samples are buffered in an internal FIFO, and the block supports mono duplication, mute and a selectable underrun policy. It sits between the sample-fetch logic (ROM or SDRAM reader) and the Arduino-header I2S pins.

---
 rtl/i2s_tx_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - I2S transmit engine with frame FIFO, mono, mute and underrun policy
module i2s_tx_fifo #(
    parameter int SAMPLE_W    = 8,
    parameter int SLOT_W      = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             sclk_in,
    input  logic                             lrclk_in,
    output logic                             sd_out,
    input  logic [2*SAMPLE_W-1:0]            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             enable,
    input  logic                             mono,
    input  logic                             underrun_zero,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      underrun_cnt,
    output logic                             frame_tick
);

    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int IDX_W   = $clog2(SLOT_W + 1);
    localparam int FRAME_W = 2 * SAMPLE_W;

    typedef enum logic {
        ST_UNARMED,
        ST_ARMED
    } arm_state_t;

    arm_state_t              state, state_n;

    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  lr_sync;
    logic                    sclk_s;
    logic                    lr_s;
    logic                    sclk_d;
    logic                    lr_d;
    logic                    fall_evt;
    logic                    slot_start;
    logic                    left_start;
    logic                    right_start;

    logic                    lr_prev;
    logic [IDX_W-1:0]        bit_idx;
    logic [IDX_W-1:0]        idx_n;
    logic [SAMPLE_W-1:0]     cur_smp;
    logic [SAMPLE_W-1:0]     cur_n;
    logic [SAMPLE_W-1:0]     smp_shift;

    logic [FRAME_W-1:0]      hold_frame;
    logic [FRAME_W-1:0]      last_frame;
    logic [FRAME_W-1:0]      load_frame;
    logic [SAMPLE_W-1:0]     hold_l;
    logic [SAMPLE_W-1:0]     hold_r;

    logic [FRAME_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [FRAME_W-1:0]      rd_frame;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    underrun;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign lr_s        = lr_sync[SYNC_STAGES-1];
    assign fall_evt    = sclk_d & ~sclk_s;
    // lr_d is the word clock as it stood just before the SCLK fall, so an LRCLK
    // change launched on a falling edge is only seen at the following fall,
    // which yields the one-bit I2S delay.
    assign slot_start  = fall_evt && (lr_d != lr_prev);
    assign left_start  = slot_start && !lr_d;
    assign right_start = slot_start && lr_d;
    assign frame_tick  = left_start;

    assign hold_l      = hold_frame[FRAME_W-1:SAMPLE_W];
    assign hold_r      = hold_frame[SAMPLE_W-1:0];
    assign rd_frame    = mem[rd_ptr];
    assign fifo_empty  = (fifo_level == '0);
    assign s_ready     = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push        = s_valid && s_ready;
    assign pop         = left_start && enable && !fifo_empty;
    assign underrun    = left_start && enable && fifo_empty;

    // Pin synchronisers plus one extra flop each for edge and pre-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sclk_d    <= 1'b0;
            lr_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_in};
            sclk_d    <= sclk_s;
            lr_d      <= lr_s;
        end
    end

    // Arming state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_UNARMED;
        end else begin
            state <= state_n;
        end
    end

    // The first left-slot start arms the block for good.
    always_comb begin
        state_n = state;
        if (left_start) begin
            state_n = ST_ARMED;
        end
    end

    // Frame selection at a left start, slot sample selection and next bit index.
    always_comb begin
        load_frame = hold_frame;
        if (!enable) begin
            load_frame = '0;
        end else if (!fifo_empty) begin
            load_frame = rd_frame;
        end else if (underrun_zero) begin
            load_frame = '0;
        end else begin
            load_frame = last_frame;
        end

        cur_n = cur_smp;
        if (left_start) begin
            cur_n = load_frame[FRAME_W-1:SAMPLE_W];
        end else if (right_start) begin
            cur_n = (state == ST_ARMED) ? (mono ? hold_l : hold_r) : '0;
        end

        if (slot_start) begin
            idx_n = '0;
        end else if (bit_idx == IDX_W'(SLOT_W)) begin
            idx_n = bit_idx;
        end else begin
            idx_n = bit_idx + IDX_W'(1);
        end

        // Shifting past the sample width leaves zeros, which pads the slot tail.
        smp_shift = cur_n << idx_n;
    end

    // Serial bit position and the registered data pin, advanced on SCLK falls only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lr_prev <= 1'b1;
            bit_idx <= '0;
            cur_smp <= '0;
            sd_out  <= 1'b0;
        end else if (fall_evt) begin
            lr_prev <= lr_d;
            bit_idx <= idx_n;
            cur_smp <= cur_n;
            sd_out  <= smp_shift[SAMPLE_W-1];
        end
    end

    // Holding pair, repeat-on-underrun copy and the saturating underrun counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_frame   <= '0;
            last_frame   <= '0;
            underrun_cnt <= '0;
        end else begin
            if (left_start) begin
                hold_frame <= load_frame;
            end
            if (pop) begin
                last_frame <= rd_frame;
            end
            if (underrun && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    // FIFO storage; contents are discarded on reset through the pointers.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

endmodule
